// File: rtl/alu_issue_ctrl_if.sv
// Command/response channel between the instruction front end (master) and alu_issue_ctrl (slave).
interface alu_issue_ctrl_if #(
    parameter int ADDR_W = 5
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [5:0]        cmd_func;
    logic [ADDR_W-1:0] cmd_rs;
    logic [ADDR_W-1:0] cmd_rt;
    logic [ADDR_W-1:0] cmd_rd;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_data;
    logic              rsp_zf;
    logic              rsp_of;
    logic              rsp_err;

    modport master (
        output cmd_valid, cmd_func, cmd_rs, cmd_rt, cmd_rd, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_zf, rsp_of, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_func, cmd_rs, cmd_rt, cmd_rd, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_zf, rsp_of, rsp_err
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issues R-type commands to an external combinational ALU, writes results back to a local register file.
// Optional macro ALU_ISSUE_TRAP_OF_EN: add/sub overflow suppresses writeback and flags rsp_err.
module alu_issue_ctrl #(
    parameter int          ADDR_W  = 5,
    parameter logic [31:0] RST_VAL = 32'h0
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_issue_ctrl_if.slave   bus_if,
    output logic [31:0]       alu_a_o,
    output logic [31:0]       alu_b_o,
    output logic [2:0]        alu_op_o,
    input  logic [31:0]       alu_f_i,
    input  logic              alu_zf_i,
    input  logic              alu_of_i,
    input  logic              host_we_i,
    input  logic [ADDR_W-1:0] host_waddr_i,
    input  logic [31:0]       host_wdata_i,
    input  logic [ADDR_W-1:0] host_raddr_i,
    output logic [31:0]       host_rdata_o
);

    localparam int NREGS = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       alu_a_q, alu_a_d;
    logic [31:0]       alu_b_q, alu_b_d;
    logic [2:0]        alu_op_q, alu_op_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic              illegal_q, illegal_d;
    logic [31:0]       rsp_data_q, rsp_data_d;
    logic              rsp_zf_q, rsp_zf_d;
    logic              rsp_of_q, rsp_of_d;
    logic              rsp_err_q, rsp_err_d;

    logic [31:0]       rf_q [NREGS];
    logic [31:0]       rs_val, rt_val;
    logic              dec_legal, dec_sllv;
    logic [2:0]        dec_op;
    logic              trap;
    logic              rf_we;
    logic              host_wr_en;

    assign rs_val       = (bus_if.cmd_rs == '0)  ? 32'h0 : rf_q[bus_if.cmd_rs];
    assign rt_val       = (bus_if.cmd_rt == '0)  ? 32'h0 : rf_q[bus_if.cmd_rt];
    assign host_rdata_o = (host_raddr_i == '0)   ? 32'h0 : rf_q[host_raddr_i];

    assign bus_if.cmd_ready = (state_q == IDLE);
    assign bus_if.rsp_valid = (state_q == RESP);
    assign bus_if.rsp_data  = rsp_data_q;
    assign bus_if.rsp_zf    = rsp_zf_q;
    assign bus_if.rsp_of    = rsp_of_q;
    assign bus_if.rsp_err   = rsp_err_q;

    assign alu_a_o  = alu_a_q;
    assign alu_b_o  = alu_b_q;
    assign alu_op_o = alu_op_q;

`ifdef ALU_ISSUE_TRAP_OF_EN
    assign trap = alu_of_i && !illegal_q && (alu_op_q == 3'b100 || alu_op_q == 3'b101);
`else
    assign trap = 1'b0;
`endif

    always_comb begin
        dec_legal = 1'b1;
        dec_op    = 3'b000;
        dec_sllv  = 1'b0;
        case (bus_if.cmd_func)
            6'b100100: dec_op = 3'b000;
            6'b100101: dec_op = 3'b001;
            6'b100110: dec_op = 3'b010;
            6'b100111: dec_op = 3'b011;
            6'b100000: dec_op = 3'b100;
            6'b100010: dec_op = 3'b101;
            6'b101010: dec_op = 3'b110;
            6'b000100: begin
                dec_op   = 3'b111;
                dec_sllv = 1'b1;
            end
            default:   dec_legal = 1'b0;
        endcase
    end

    // sllv swaps operands so the ALU always shifts A by B[4:0]
    always_comb begin
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        rd_d       = rd_q;
        illegal_d  = illegal_q;
        rsp_data_d = rsp_data_q;
        rsp_zf_d   = rsp_zf_q;
        rsp_of_d   = rsp_of_q;
        rsp_err_d  = rsp_err_q;
        rf_we      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus_if.cmd_valid) begin
                    state_d   = EXEC;
                    rd_d      = bus_if.cmd_rd;
                    illegal_d = !dec_legal;
                    alu_op_d  = dec_op;
                    if (!dec_legal) begin
                        alu_a_d = 32'h0;
                        alu_b_d = 32'h0;
                    end else if (dec_sllv) begin
                        alu_a_d = rt_val;
                        alu_b_d = rs_val;
                    end else begin
                        alu_a_d = rs_val;
                        alu_b_d = rt_val;
                    end
                end
            end
            EXEC: begin
                state_d    = RESP;
                rsp_data_d = illegal_q ? 32'h0 : alu_f_i;
                rsp_zf_d   = alu_zf_i;
                rsp_of_d   = alu_of_i;
                rsp_err_d  = illegal_q || trap;
                rf_we      = (rd_q != '0) && !illegal_q && !trap;
            end
            RESP: begin
                if (bus_if.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign host_wr_en = host_we_i && (state_q == IDLE) && (host_waddr_i != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            alu_a_q    <= 32'h0;
            alu_b_q    <= 32'h0;
            alu_op_q   <= 3'b000;
            rd_q       <= '0;
            illegal_q  <= 1'b0;
            rsp_data_q <= 32'h0;
            rsp_zf_q   <= 1'b0;
            rsp_of_q   <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            rd_q       <= rd_d;
            illegal_q  <= illegal_d;
            rsp_data_q <= rsp_data_d;
            rsp_zf_q   <= rsp_zf_d;
            rsp_of_q   <= rsp_of_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    // Host writes only land in IDLE and writeback only in EXEC, so the two never collide
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= RST_VAL;
            end
        end else begin
            if (host_wr_en) begin
                rf_q[host_waddr_i] <= host_wdata_i;
            end
            if (rf_we) begin
                rf_q[rd_q] <= alu_f_i;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: random and directed R-type commands against a funct-level reference model.
module tb_alu_issue_ctrl;

    localparam int ADDR_W = 5;

    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLLV = 6'b000100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_issue_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    logic [31:0] aluA, aluB, aluF;
    logic [2:0]  aluOp;
    logic        aluZf, aluOf;
    logic        hostWe;
    logic [4:0]  hostWaddr, hostRaddr;
    logic [31:0] hostWdata, hostRdata;

    alu_issue_ctrl #(.ADDR_W(ADDR_W), .RST_VAL(32'h0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus_if       (bus.slave),
        .alu_a_o      (aluA),
        .alu_b_o      (aluB),
        .alu_op_o     (aluOp),
        .alu_f_i      (aluF),
        .alu_zf_i     (aluZf),
        .alu_of_i     (aluOf),
        .host_we_i    (hostWe),
        .host_waddr_i (hostWaddr),
        .host_wdata_i (hostWdata),
        .host_raddr_i (hostRaddr),
        .host_rdata_o (hostRdata)
    );

    // Stand-in for the combinational ALU the controller drives
    always_comb begin
        case (aluOp)
            3'b000:  aluF = aluA & aluB;
            3'b001:  aluF = aluA | aluB;
            3'b010:  aluF = aluA ^ aluB;
            3'b011:  aluF = ~(aluA | aluB);
            3'b100:  aluF = aluA + aluB;
            3'b101:  aluF = aluA - aluB;
            3'b110:  aluF = ($signed(aluA) < $signed(aluB)) ? 32'd1 : 32'd0;
            default: aluF = aluA << aluB[4:0];
        endcase
        aluZf = (aluF == 32'h0);
        aluOf = 1'b0;
        if (aluOp == 3'b100) aluOf = (aluA[31] == aluB[31]) && (aluF[31] != aluA[31]);
        if (aluOp == 3'b101) aluOf = (aluA[31] != aluB[31]) && (aluF[31] != aluA[31]);
    end

    typedef struct {
        logic [31:0] data;
        logic        zf;
        logic        of;
        logic        err;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        int          acceptCyc;
    } exp_t;

    exp_t        expQ[$];
    logic [31:0] refRf [32];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          longStall = 1'b0;

    always @(posedge clk) cyc++;

    function automatic logic [31:0] refRead(input logic [4:0] addr);
        return (addr == 5'd0) ? 32'h0 : refRf[addr];
    endfunction

    // Reference: result straight from the funct meaning, overflow from wide signed arithmetic
    function automatic exp_t modelExec(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                                       output bit wr);
        exp_t   e;
        longint sx, sy, r;
        sx = $signed(x);
        sy = $signed(y);
        e.a = x; e.b = y; e.of = 1'b0; e.err = 1'b0; e.acceptCyc = 0;
        wr = 1'b1;
        case (f)
            F_AND: begin e.op = 3'd0; e.data = x & y; end
            F_OR:  begin e.op = 3'd1; e.data = x | y; end
            F_XOR: begin e.op = 3'd2; e.data = x ^ y; end
            F_NOR: begin e.op = 3'd3; e.data = ~(x | y); end
            F_ADD: begin
                e.op = 3'd4; r = sx + sy; e.data = r[31:0];
                e.of = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            end
            F_SUB: begin
                e.op = 3'd5; r = sx - sy; e.data = r[31:0];
                e.of = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            end
            F_SLT:  begin e.op = 3'd6; e.data = (sx < sy) ? 32'd1 : 32'd0; end
            F_SLLV: begin e.op = 3'd7; e.a = y; e.b = x; e.data = y << x[4:0]; end
            default: begin
                e.op = 3'd0; e.a = 32'h0; e.b = 32'h0; e.data = 32'h0; e.err = 1'b1; wr = 1'b0;
            end
        endcase
        e.zf = (e.data == 32'h0);
`ifdef ALU_ISSUE_TRAP_OF_EN
        if (e.of) begin
            e.err = 1'b1;
            wr = 1'b0;
        end
`endif
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic waitIdle();
        int n = 0;
        while (!bus.cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cmd_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL idle_timeout: cmd_ready stayed %b, expected 1", bus.cmd_ready);
        end
    endtask

    task automatic waitDone();
        int n = 0;
        while ((expQ.size() != 0 || !bus.cmd_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (expQ.size() != 0 || !bus.cmd_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout: %0d responses outstanding, cmd_ready=%b", expQ.size(), bus.cmd_ready);
        end
    endtask

    task automatic hostWrite(input logic [4:0] addr, input logic [31:0] data);
        waitIdle();
        hostWe = 1'b1; hostWaddr = addr; hostWdata = data;
        @(negedge clk);
        hostWe = 1'b0;
        if (addr != 5'd0) refRf[addr] = data;
    endtask

    task automatic checkReg(input logic [4:0] addr);
        hostRaddr = addr;
        #1;
        checkOutput($sformatf("reg%0d", addr), hostRdata, refRead(addr));
    endtask

    // Returns at the negedge of the EXEC cycle
    task automatic applyStimulus(input logic [5:0] f, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] rd, input bit hwe = 1'b0,
                                 input logic [4:0] hwa = 5'd0, input logic [31:0] hwd = 32'h0);
        exp_t e;
        bit   wr;
        waitIdle();
        e = modelExec(f, refRead(rs), refRead(rt), wr);
        e.acceptCyc = cyc;
        expQ.push_back(e);
        if (hwe && hwa != 5'd0) refRf[hwa] = hwd;
        if (wr && rd != 5'd0) refRf[rd] = e.data;
        bus.cmd_valid = 1'b1; bus.cmd_func = f; bus.cmd_rs = rs; bus.cmd_rt = rt; bus.cmd_rd = rd;
        hostWe = hwe; hostWaddr = hwa; hostWdata = hwd;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        hostWe = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever a new response appears, then back-pressures randomly
    initial begin
        exp_t e;
        int   stall;
        bus.rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.rsp_valid) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_rsp: got rsp_data %h with no command outstanding", bus.rsp_data);
                    e.data = bus.rsp_data; e.zf = 1'b0; e.of = 1'b0; e.err = 1'b0;
                end else begin
                    e = expQ.pop_front();
                    checkOutput("rsp_data", bus.rsp_data, e.data);
                    checkOutput("rsp_zf", 32'(bus.rsp_zf), 32'(e.zf));
                    checkOutput("rsp_of", 32'(bus.rsp_of), 32'(e.of));
                    checkOutput("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                    checkOutput("alu_a", aluA, e.a);
                    checkOutput("alu_b", aluB, e.b);
                    checkOutput("alu_op", 32'(aluOp), 32'(e.op));
                    checkOutput("latency", 32'(cyc - e.acceptCyc), 32'd2);
                end
                stall = longStall ? 10 : $urandom_range(0, 3);
                for (int i = 0; i < stall; i++) begin
                    @(negedge clk);
                    checkOutput("hold_valid", 32'(bus.rsp_valid), 32'd1);
                    checkOutput("hold_data", bus.rsp_data, e.data);
                    checkOutput("hold_err", 32'(bus.rsp_err), 32'(e.err));
                    checkOutput("hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
                end
                bus.rsp_ready = 1'b1;
                @(negedge clk);
                bus.rsp_ready = 1'b0;
                checkOutput("ready_after_consume", 32'(bus.cmd_ready), 32'd1);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [5:0] legalF [8];
        logic [5:0] f;
        legalF = '{F_AND, F_OR, F_XOR, F_NOR, F_ADD, F_SUB, F_SLT, F_SLLV};
        for (int i = 0; i < 32; i++) refRf[i] = 32'h0;
        bus.cmd_valid = 1'b0; bus.cmd_func = 6'h0; bus.cmd_rs = '0; bus.cmd_rt = '0; bus.cmd_rd = '0;
        hostWe = 1'b0; hostWaddr = 5'd0; hostWdata = 32'h0; hostRaddr = 5'd0;

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("reset_rsp_data", bus.rsp_data, 32'h0);
        checkOutput("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
        checkOutput("reset_alu_a", aluA, 32'h0);
        checkOutput("reset_alu_op", 32'(aluOp), 32'd0);
        checkReg(5'd7);
        rst_n = 1'b1;
        @(negedge clk);

        hostWrite(5'd1, 32'd7); hostWrite(5'd2, 32'd5);
        applyStimulus(F_ADD, 5'd1, 5'd2, 5'd3);
        waitDone(); checkReg(5'd3);

        hostWrite(5'd1, 32'd5); hostWrite(5'd2, 32'd5);
        applyStimulus(F_SUB, 5'd1, 5'd2, 5'd4);
        hostWrite(5'd1, 32'hFFFF_FFFF); hostWrite(5'd2, 32'd1);
        applyStimulus(F_SLT, 5'd1, 5'd2, 5'd4);
        waitDone(); checkReg(5'd4);

        hostWrite(5'd1, 32'h7FFF_FFFF); hostWrite(5'd2, 32'd1);
        applyStimulus(F_ADD, 5'd1, 5'd2, 5'd5);
        waitDone(); checkReg(5'd5);

        hostWrite(5'd1, 32'd3); hostWrite(5'd2, 32'd1);
        applyStimulus(F_SLLV, 5'd1, 5'd2, 5'd6);
        waitDone(); checkReg(5'd6);

        hostWrite(5'd7, 32'hCAFE_0007);
        applyStimulus(6'b001000, 5'd1, 5'd2, 5'd7);
        waitDone(); checkReg(5'd7);

        applyStimulus(F_ADD, 5'd1, 5'd2, 5'd0);
        waitDone(); checkReg(5'd0);

        longStall = 1'b1;
        applyStimulus(F_XOR, 5'd6, 5'd7, 5'd8);
        waitDone();
        longStall = 1'b0;

        // Host write asserted through EXEC and RESP must be dropped
        hostWrite(5'd9, 32'h0000_1234);
        applyStimulus(F_OR, 5'd1, 5'd2, 5'd10);
        hostWe = 1'b1; hostWaddr = 5'd9; hostWdata = 32'hDEAD_BEEF;
        @(negedge clk);
        @(negedge clk);
        hostWe = 1'b0;
        waitDone(); checkReg(5'd9); checkReg(5'd10);

        // Host write on the accept edge: operands see the old R1
        hostWrite(5'd1, 32'd10); hostWrite(5'd2, 32'd20);
        applyStimulus(F_ADD, 5'd1, 5'd2, 5'd11, 1'b1, 5'd1, 32'd100);
        waitDone(); checkReg(5'd11); checkReg(5'd1);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                hostWrite(5'($urandom_range(1, 7)),
                          ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF + 32'($urandom_range(0, 2)) : $urandom);
            end
            f = ($urandom_range(0, 8) == 0) ? 6'($urandom_range(0, 63)) : legalF[$urandom_range(0, 7)];
            applyStimulus(f, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        waitDone();
        for (int r = 0; r < 8; r++) checkReg(5'(r));

        // Reset pulsed during EXEC abandons the command entirely
        waitIdle();
        bus.cmd_valid = 1'b1; bus.cmd_func = F_ADD; bus.cmd_rs = 5'd1; bus.cmd_rt = 5'd2; bus.cmd_rd = 5'd12;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) refRf[i] = 32'h0;
        checkOutput("rst_exec_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        checkOutput("rst_exec_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        checkReg(5'd12); checkReg(5'd1);

        hostWrite(5'd1, 32'h8000_0000); hostWrite(5'd2, 32'h8000_0000);
        applyStimulus(F_ADD, 5'd1, 5'd2, 5'd13);
        waitDone(); checkReg(5'd13);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
